// File: rtl/w_input_conditioner_if.sv
// Signal bundle between the switch conditioner and the run-detector side.
// The glitch_cnt member exists only when W_GLITCH_CNT_EN is defined.
interface w_input_conditioner_if;
  logic       sw_raw;
  logic       w;
  logic       w_rise;
  logic       w_fall;
  logic       tick;
  logic [1:0] st;
`ifdef W_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  modport master (
    input  sw_raw,
    output w,
    output w_rise,
    output w_fall,
    output tick,
`ifdef W_GLITCH_CNT_EN
    output glitch_cnt,
`endif
    output st
  );

  modport slave (
    output sw_raw,
    input  w,
    input  w_rise,
    input  w_fall,
    input  tick,
`ifdef W_GLITCH_CNT_EN
    input  glitch_cnt,
`endif
    input  st
  );
endinterface

// File: rtl/w_input_conditioner.sv
// Synchronises, prescale-samples and debounces a raw switch into level w plus edge strobes.
// Optional feature macro: W_GLITCH_CNT_EN adds a saturating aborted-check counter.
module w_input_conditioner #(
  parameter int DIV_W      = 16,
  parameter int DIV_MAX    = 49999,
  parameter int STABLE_CNT = 4
) (
  input logic                    clk,
  input logic                    aclr,
  w_input_conditioner_if.master  bus
);

  typedef enum logic [1:0] {
    LO     = 2'b00,
    CHK_HI = 2'b01,
    HI     = 2'b10,
    CHK_LO = 2'b11
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX);
  localparam logic [3:0]       CNT_LAST = 4'(STABLE_CNT - 1);
  localparam bit               ONE_SHOT = (STABLE_CNT == 1);

  logic             s1_r;
  logic             s2_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             tick_s;
  state_t           state_r;
  state_t           state_n;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_n;
  logic             abort_s;
  logic             w_rise_r;
  logic             w_fall_r;

  // Two-flop synchroniser for the asynchronous switch level
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= bus.sw_raw;
      s2_r <= s1_r;
    end
  end

  assign tick_s = (div_cnt_r == DIV_LAST);

  // Free-running prescaler producing the sample tick
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Debounce state and stability counter registers
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_r <= LO;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next-state logic; only tick cycles may move the FSM
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    abort_s = 1'b0;
    if (tick_s) begin
      case (state_r)
        LO: begin
          if (s2_r && ONE_SHOT) begin
            state_n = HI;
            cnt_n   = 4'd0;
          end else if (s2_r) begin
            state_n = CHK_HI;
            cnt_n   = 4'd1;
          end else begin
            state_n = LO;
            cnt_n   = 4'd0;
          end
        end
        CHK_HI: begin
          if (s2_r && (cnt_r == CNT_LAST)) begin
            state_n = HI;
            cnt_n   = 4'd0;
          end else if (s2_r) begin
            cnt_n   = cnt_r + 4'd1;
          end else begin
            state_n = LO;
            cnt_n   = 4'd0;
            abort_s = 1'b1;
          end
        end
        HI: begin
          if (!s2_r && ONE_SHOT) begin
            state_n = LO;
            cnt_n   = 4'd0;
          end else if (!s2_r) begin
            state_n = CHK_LO;
            cnt_n   = 4'd1;
          end else begin
            state_n = HI;
            cnt_n   = 4'd0;
          end
        end
        CHK_LO: begin
          if (!s2_r && (cnt_r == CNT_LAST)) begin
            state_n = LO;
            cnt_n   = 4'd0;
          end else if (!s2_r) begin
            cnt_n   = cnt_r + 4'd1;
          end else begin
            state_n = HI;
            cnt_n   = 4'd0;
            abort_s = 1'b1;
          end
        end
        default: begin
          state_n = LO;
          cnt_n   = 4'd0;
        end
      endcase
    end else begin
      state_n = state_r;
      cnt_n   = cnt_r;
    end
  end

  // Edge strobes line up with the first clk the new w level is visible
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      w_rise_r <= 1'b0;
      w_fall_r <= 1'b0;
    end else begin
      w_rise_r <= state_n[1] & ~state_r[1];
      w_fall_r <= ~state_n[1] & state_r[1];
    end
  end

  assign bus.w      = state_r[1];
  assign bus.w_rise = w_rise_r;
  assign bus.w_fall = w_fall_r;
  assign bus.tick   = tick_s;
  assign bus.st     = state_r;

`ifdef W_GLITCH_CNT_EN
  logic [7:0] glitch_r;

  // Saturating count of aborted stability checks
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      glitch_r <= 8'd0;
    end else if (abort_s && (glitch_r != 8'hFF)) begin
      glitch_r <= glitch_r + 8'd1;
    end else begin
      glitch_r <= glitch_r;
    end
  end

  assign bus.glitch_cnt = glitch_r;
`endif

endmodule

// File: tb/tb_w_input_conditioner.sv
// Randomised scoreboard bench: a run-length reference model predicts w, st, tick and edge strobes
// for a STABLE_CNT=3 instance and a STABLE_CNT=1 instance driven with the same switch waveform.
module tb_w_input_conditioner;
  localparam int DIV_MAX = 3;

  logic clk;
  logic aclr;
  int   tests = 0;
  int   fails = 0;

  w_input_conditioner_if bus_a ();
  w_input_conditioner_if bus_b ();

  w_input_conditioner #(.DIV_W(16), .DIV_MAX(DIV_MAX), .STABLE_CNT(3)) dut_a (
    .clk(clk), .aclr(aclr), .bus(bus_a.master));
  w_input_conditioner #(.DIV_W(16), .DIV_MAX(DIV_MAX), .STABLE_CNT(1)) dut_b (
    .clk(clk), .aclr(aclr), .bus(bus_b.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sampled level pipeline, tick phase, committed level and run of disagreeing samples
  int m_s1[2], m_s2[2], m_div[2], m_w[2], m_run[2], m_glitch[2];
  int stab[2] = '{3, 1};
  int m_cyc = 0;
  int q0[$];
  int q1[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_div[i] = 0; m_w[i] = 0; m_run[i] = 0; m_glitch[i] = 0;
    end
    forever begin
      @(posedge clk);
      m_cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!aclr) begin
          m_s1[i] = 0; m_s2[i] = 0; m_div[i] = 0; m_w[i] = 0; m_run[i] = 0; m_glitch[i] = 0;
        end else begin
          int tk;
          tk = (m_div[i] == DIV_MAX) ? 1 : 0;
          if (tk == 1) begin
            if (m_s2[i] != m_w[i]) begin
              m_run[i]++;
              if (m_run[i] == stab[i]) begin
                m_w[i]   = 1 - m_w[i];
                m_run[i] = 0;
                if (i == 0) q0.push_back(m_cyc * 2 + m_w[i]);
                else        q1.push_back(m_cyc * 2 + m_w[i]);
              end
            end else begin
              if (m_run[i] > 0 && m_glitch[i] < 255) m_glitch[i]++;
              m_run[i] = 0;
            end
          end
          m_div[i] = (tk == 1) ? 0 : m_div[i] + 1;
          m_s2[i]  = m_s1[i];
          m_s1[i]  = (i == 0) ? int'(bus_a.sw_raw) : int'(bus_b.sw_raw);
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int w, r, f, tk, st, exp_r, exp_f, head;
        bit have;
        w  = (i == 0) ? int'(bus_a.w)      : int'(bus_b.w);
        r  = (i == 0) ? int'(bus_a.w_rise) : int'(bus_b.w_rise);
        f  = (i == 0) ? int'(bus_a.w_fall) : int'(bus_b.w_fall);
        tk = (i == 0) ? int'(bus_a.tick)   : int'(bus_b.tick);
        st = (i == 0) ? int'(bus_a.st)     : int'(bus_b.st);
        check($sformatf("w[%0d]", i), w, m_w[i]);
        check($sformatf("st[%0d]", i), st, m_w[i] * 2 + ((m_run[i] != 0) ? 1 : 0));
        check($sformatf("tick[%0d]", i), tk, (m_div[i] == DIV_MAX) ? 1 : 0);
        check($sformatf("both_strobes[%0d]", i), r & f, 0);
        exp_r = 0;
        exp_f = 0;
        have  = 1'b0;
        head  = 0;
        if (i == 0 && q0.size() > 0 && (q0[0] >> 1) <= m_cyc) begin head = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0 && (q1[0] >> 1) <= m_cyc) begin head = q1.pop_front(); have = 1'b1; end
        if (have) begin
          check($sformatf("strobe_cycle[%0d]", i), head >> 1, m_cyc);
          exp_r = head & 1;
          exp_f = 1 - (head & 1);
        end
        check($sformatf("w_rise[%0d]", i), r, exp_r);
        check($sformatf("w_fall[%0d]", i), f, exp_f);
        if (i == 1) check("st_b_no_chk", st & 1, 0);
      end
`ifdef W_GLITCH_CNT_EN
      check("glitch_cnt", int'(bus_a.glitch_cnt), m_glitch[0]);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic set_sw(input logic v);
    bus_a.sw_raw = v;
    bus_b.sw_raw = v;
  endtask

  initial begin
    int waited;
    aclr = 1'b0;
    set_sw(1'b0);
    // Reset with the switch toggling
    for (int k = 0; k < 5; k++) begin
      step(1);
      set_sw(~bus_a.sw_raw);
    end
    step(1);
    set_sw(1'b0);
    aclr = 1'b1;
    step(6);
    // Clean rise, short glitch, clean fall
    set_sw(1'b1);
    step(30);
    set_sw(1'b0);
    step(30);
    set_sw(1'b1);
    step(6);
    set_sw(1'b0);
    step(30);
    set_sw(1'b1);
    step(30);
    set_sw(1'b0);
    step(30);
    // Reset in the middle of a rising check with two samples accepted
    set_sw(1'b1);
    waited = 0;
    while (!(m_w[0] == 0 && m_run[0] == 2) && waited < 100) begin
      step(1);
      waited++;
    end
    check("chk_wait_timeout", (waited < 100) ? 1 : 0, 1);
    aclr = 1'b0;
    #1;
    check("async_w", int'(bus_a.w), 0);
    check("async_st", int'(bus_a.st), 0);
    step(1);
    aclr = 1'b1;
    step(30);
    // Randomised level segments
    for (int k = 0; k < 200; k++) begin
      set_sw(1'($urandom_range(0, 1)));
      step($urandom_range(1, 24));
    end
    set_sw(1'b0);
    step(40);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/w_input_conditioner.md
Name: w_input_conditioner

Overview:
Upstream stage that produces the serial input w for the run-detector FSM from a raw board switch or key.
Synchronises the asynchronous raw input into clk, samples it on a prescaled tick, and debounces it.
Debouncing uses a 4-state FSM with a stability counter.
Outputs a clean level w plus single-cycle edge strobes; w changes at most once per committed debounce interval.

Parameters:
DIV_W, 16, width of prescaler counter
DIV_MAX, 49999, prescaler terminal count; tick period = DIV_MAX+1 clk (1 ms at 50 MHz); legal range 0..2^DIV_W-1
STABLE_CNT, 4, consecutive equal tick samples required to commit a level change; legal range 1..15

Ports:
clk  in  1  system clock
aclr  in  1  asynchronous active-low reset
sw_raw  in  1  raw asynchronous switch/key level
w  out  1  debounced level, feeds detector input w
w_rise  out  1  one-clk pulse on w 0->1
w_fall  out  1  one-clk pulse on w 1->0
tick  out  1  one-clk sample strobe from prescaler
st  out  2  current FSM state code, debug

Behaviour:
- Reset: aclr is asynchronous, active-low; clock is clk. While aclr=0, all registers clear: sync flops=0, div_cnt=0, cnt=0, state=LO.
  Outputs during reset: w=0, w_rise=0, w_fall=0, tick=0, st=2'b00.
- Synchroniser: two flops, s1<=sw_raw, s2<=s1; sw_s=s2; 2-clk latency.
- Prescaler: div_cnt counts 0..DIV_MAX, then wraps to 0.
  tick=1 combinationally when div_cnt==DIV_MAX. DIV_MAX=0 gives tick every clk.
- FSM state codes: LO=00, CHK_HI=01, HI=10, CHK_LO=11. State and cnt advance only on clocks with tick=1; otherwise hold.
- LO: sw_s=1 -> if STABLE_CNT==1 go HI, else go CHK_HI with cnt=1. sw_s=0 -> stay.
- CHK_HI: sw_s=1 and cnt==STABLE_CNT-1 -> HI, cnt=0. sw_s=1 otherwise -> cnt+1. sw_s=0 -> LO, cnt=0 (aborted check).
- HI / CHK_LO: mirror of LO / CHK_HI with levels inverted.
- Derived outputs:
  - w=1 in HI and CHK_LO, w=0 in LO and CHK_HI; w is decoded from the state register, so it is glitch-free.
  - w changes on the clk edge that ends the committing tick cycle.
  - w_rise/w_fall are registered and assert for exactly the first clk in which the new w is visible.
- Latency from a clean sw_raw step to w change: 2 clk (sync) + wait to next tick + (STABLE_CNT-1) further ticks + 1 clk.
- A sw_raw pulse shorter than STABLE_CNT consecutive tick samples never changes w. CHK states never entered when STABLE_CNT==1.
- w_rise and w_fall are never both 1. No two edge strobes closer than STABLE_CNT ticks, except STABLE_CNT==1 (one tick).
- Reset mid-operation (any state, any cnt): immediate return to LO, w=0; a new change needs the full STABLE_CNT ticks after release.
- No latch-inferring paths; all unreachable state codes are impossible (2-bit fully encoded).

Optional Feature:
W_GLITCH_CNT_EN: when defined, adds output port glitch_cnt [7:0].
- Increments on every aborted check (CHK_HI->LO or CHK_LO->HI transition).
- Saturates at 255 and clears on aclr.
When undefined, the port and its counter are absent; all other behaviour is identical.

Test Plan:
All scenarios use DIV_MAX=3, STABLE_CNT=3.
1. aclr=0 for 5 clk with sw_raw toggling -> w=0, w_rise=0, w_fall=0, tick=0, st=00 throughout; first tick 4 clk after aclr release.
2. sw_raw 0->1 held -> st 00->01->01->10 on three successive ticks; w=1 one clk after 3rd sampled-high tick; w_rise high exactly 1 clk.
3. sw_raw high for 6 clk then low (≤2 high tick samples) -> w stays 0, st returns 00; glitch_cnt=1 if W_GLITCH_CNT_EN.
4. From HI, sw_raw 1->0 held -> w_fall single pulse after 3 low tick samples; w=0; w_rise never asserted.
5. aclr pulsed low while st=01 with cnt=2 -> w=0, st=00 immediately; after release, sw_raw still high needs 3 new ticks before w=1.
6. STABLE_CNT=1 build, sw_raw toggled every 8 clk -> w follows each level one tick later; st never 01 or 11.
